// File: rtl/acc_csv_resolve.sv
// Carry-save accumulator: 4:2 compresses one (PS, PC) beat per cycle, then
// resolves to binary one chunk per cycle and presents the sum with valid/ready.
module acc_csv_resolve #(
    parameter int unsigned width    = 16,
    parameter int unsigned accWidth = 24,
    parameter int unsigned chunk    = 8,
    parameter int unsigned cntWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [width-1:0]    ps_i,
    input  logic [width-1:0]    pc_i,
    input  logic                last_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [accWidth-1:0] sum_o,
    output logic [cntWidth-1:0] cnt_o,
    output logic                valid_o,
    input  logic                ready_i
);

    localparam int unsigned N  = accWidth / chunk;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [accWidth-1:0] acc_s_q, acc_c_q;
    logic [accWidth-1:0] res_q;
    logic [cntWidth-1:0] cnt_q;
    logic [KW-1:0]       k_q;
    logic                carry_q;

    logic                accept_c;
    logic                k_last_c;
    logic [accWidth-1:0] ps_ext_c, pc_ext_c;
    logic [accWidth-1:0] s1_c, c1_c, s2_c, c2_c;
    logic [chunk:0]      csum_c;
    logic [accWidth-1:0] res_next_c;

    assign ready_o  = (state_q == ACC);
    assign accept_c = valid_i && ready_o;
    assign k_last_c = (k_q == KW'(N - 1));

    // Two 3:2 layers; carries shift left and drop the bit out of the MSB.
    always_comb begin
        ps_ext_c = accWidth'(ps_i);
        pc_ext_c = accWidth'(pc_i);
        s1_c     = acc_s_q ^ acc_c_q ^ ps_ext_c;
        c1_c     = ((acc_s_q & acc_c_q) | (acc_s_q & ps_ext_c) | (acc_c_q & ps_ext_c)) << 1;
        s2_c     = s1_c ^ c1_c ^ pc_ext_c;
        c2_c     = ((s1_c & c1_c) | (s1_c & pc_ext_c) | (c1_c & pc_ext_c)) << 1;
    end

    // One chunk of the carry-propagate resolve, selected by k.
    always_comb begin
        csum_c     = (chunk + 1)'(chunk'(acc_s_q >> (k_q * chunk)))
                   + (chunk + 1)'(chunk'(acc_c_q >> (k_q * chunk)))
                   + (chunk + 1)'(carry_q);
        res_next_c = res_q | (accWidth'(csum_c[chunk-1:0]) << (k_q * chunk));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ACC;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (accept_c && last_i) state_d = RESOLVE;
            RESOLVE: if (k_last_c)           state_d = OUT;
            OUT:     if (ready_i)            state_d = ACC;
            default:                         state_d = ACC;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_s_q <= '0;
            acc_c_q <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            sum_o   <= '0;
            cnt_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept_c) begin
                        acc_s_q <= s2_c;
                        acc_c_q <= c2_c;
                        if (cnt_q != '1) cnt_q <= cnt_q + cntWidth'(1);
                        if (last_i) begin
                            k_q     <= '0;
                            carry_q <= 1'b0;
                            res_q   <= '0;
                        end
                    end
                end
                RESOLVE: begin
                    res_q   <= res_next_c;
                    carry_q <= csum_c[chunk];
                    k_q     <= k_q + KW'(1);
                    if (k_last_c) begin
                        sum_o   <= res_next_c;
                        cnt_o   <= cnt_q;
                        valid_o <= 1'b1;
                        acc_s_q <= '0;
                        acc_c_q <= '0;
                        cnt_q   <= '0;
                        k_q     <= '0;
                    end
                end
                OUT: begin
                    if (ready_i) valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_csv_resolve.sv
// Directed bench for acc_csv_resolve: reset, latency, carries, wrap/saturation,
// backpressure and reset during resolve.
module tb_acc_csv_resolve;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] ps_i, pc_i;
    logic        last_i, valid_i, ready_o, valid_o, ready_i;
    logic [23:0] sum_o;
    logic [7:0]  cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    acc_csv_resolve dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .ps_i    (ps_i),
        .pc_i    (pc_i),
        .last_i  (last_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sum_o   (sum_o),
        .cnt_o   (cnt_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] ps, input logic [15:0] pc, input logic last);
        ps_i    = ps;
        pc_i    = pc;
        last_i  = last;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [23:0] exp_sum, input logic [7:0] exp_cnt);
        for (int i = 0; i < 20 && valid_o !== 1'b1; i++) step();
        check({tag, "_valid"}, 32'(valid_o), 32'd1);
        check({tag, "_sum"},   32'(sum_o),   32'(exp_sum));
        check({tag, "_cnt"},   32'(cnt_o),   32'(exp_cnt));
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check({tag, "_valid_clr"}, 32'(valid_o), 32'd0);
        check({tag, "_ready_back"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        rst_ni  = 1'b0;
        ready_i = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        ps_i    = '0;
        pc_i    = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            ps_i    = 16'($urandom);
            pc_i    = 16'($urandom);
            last_i  = 1'($urandom);
            valid_i = 1'($urandom);
            ready_i = 1'($urandom);
            step();
        end
        check("rst_sum",   32'(sum_o),   32'd0);
        check("rst_cnt",   32'(cnt_o),   32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        valid_i = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b0;
        rst_ni  = 1'b1;
        step();
        check("rel_sum",   32'(sum_o),   32'd0);
        check("rel_valid", 32'(valid_o), 32'd0);
        check("rel_ready", 32'(ready_o), 32'd1);

        // Single beat: exact latency and ready_o low window
        send_beat(16'h1234, 16'h0F0F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("single_busy_ready", 32'(ready_o), 32'd0);
            check("single_busy_valid", 32'(valid_o), 32'd0);
            step();
        end
        check("single_e3_ready", 32'(ready_o), 32'd0);
        take_result("single", 24'h002143, 8'd1);

        // Cross-chunk carries, back-to-back beats
        send_beat(16'hFFFF, 16'h0001, 1'b0);
        check("cross_ready1", 32'(ready_o), 32'd1);
        send_beat(16'h8000, 16'h8000, 1'b0);
        check("cross_ready2", 32'(ready_o), 32'd1);
        send_beat(16'h00FF, 16'hFF00, 1'b1);
        take_result("cross", 24'h02FFFF, 8'd3);

        // Wrap modulo 2^24 and counter saturation
        for (int i = 0; i < 256; i++) send_beat(16'hFFFF, 16'h0000, 1'b0);
        send_beat(16'hFFFF, 16'h0000, 1'b1);
        take_result("wrap", 24'h00FEFF, 8'd255);

        // Backpressure: held result, beats ignored
        send_beat(16'h0001, 16'h0002, 1'b1);
        for (int i = 0; i < 20 && valid_o !== 1'b1; i++) step();
        ps_i    = 16'h5555;
        pc_i    = 16'h0000;
        last_i  = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(valid_o), 32'd1);
            check("bp_sum",   32'(sum_o),   32'h000003);
            check("bp_cnt",   32'(cnt_o),   32'd1);
            check("bp_ready", 32'(ready_o), 32'd0);
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        check("bp_valid_clr", 32'(valid_o), 32'd0);
        check("bp_ready_back", 32'(ready_o), 32'd1);
        send_beat(16'h0007, 16'h0000, 1'b1);
        take_result("bp_next", 24'h000007, 8'd1);

        // Reset mid-resolve at k = 1
        send_beat(16'h00FF, 16'h00FF, 1'b0);
        send_beat(16'h0100, 16'h0000, 1'b1);
        step();
        rst_ni = 1'b0;
        #1;
        check("mid_rst_sum",   32'(sum_o),   32'd0);
        check("mid_rst_cnt",   32'(cnt_o),   32'd0);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_ready", 32'(ready_o), 32'd1);
        step();
        rst_ni = 1'b1;
        step();
        check("post_rst_valid", 32'(valid_o), 32'd0);
        send_beat(16'h0010, 16'h0001, 1'b1);
        take_result("post_rst", 24'h000011, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acc_csv_resolve.md
# acc_csv_resolve

Sequential accumulator that sits directly downstream of the carry-save unsigned multiplier. It consumes one carry-save product pair (PS, PC) per handshake and accumulates it in redundant carry-save form. On the last beat it resolves the accumulator to binary with a chunked, multi-cycle carry-propagate addition. It then presents the binary sum with a valid/ready handshake.

## Interface
- width, 16: word width of ps_i/pc_i (= widthX+widthY of the upstream multiplier); must be <= accWidth
- accWidth, 24: accumulator and result width; all arithmetic is modulo 2^accWidth
- chunk, 8: bits resolved per cycle; must divide accWidth; N = accWidth/chunk
- cntWidth, 8: width of the beat counter
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- ps_i  in  width  product sum vector
- pc_i  in  width  product carry vector
- last_i  in  1  the current beat closes the accumulation
- valid_i  in  1  input beat valid
- ready_o  out  1  block accepts a beat
- sum_o  out  accWidth  resolved binary sum
- cnt_o  out  cntWidth  number of beats in this result, saturating
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts the result

## Operation
- States: ACC, RESOLVE, OUT.
- Reset state: ACC, with accS = accC = 0, beat counter 0, chunk index k = 0, carry register 0.
- Output reset values: sum_o = 0, cnt_o = 0, valid_o = 0. ready_o reads 1 because the state is ACC.
- ready_o = (state == ACC). It is combinational from the state register only and never depends on valid_i.
- ACC, on valid_i && ready_o:
  - Zero-extend ps_i and pc_i to accWidth.
  - Compress {accS, accC, ps, pc} 4:2 with two 3:2 layers. Each carry vector shifts left by 1 and the bit out of position accWidth-1 is dropped.
  - Store the result in accS/accC.
  - Increment the beat counter, saturating at 2^cntWidth-1.
  - If last_i is set, go to RESOLVE with k = 0 and carry = 0.
- ACC with valid_i low: hold all state.
- RESOLVE, one cycle per k:
  - result[k*chunk +: chunk] = accS chunk k + accC chunk k + carry.
  - carry <= the carry out of that chunk; k <= k+1.
  - After k = N-1, the final carry is discarded (modulo) and the state goes to OUT.
- Entering OUT: sum_o is loaded with the full result, cnt_o with the beat counter, and valid_o is set. accS, accC and the beat counter clear in the same edge.
- OUT: sum_o, cnt_o and valid_o hold while ready_i = 0. On ready_i = 1, valid_o clears and the state returns to ACC. sum_o and cnt_o keep their last values.
- valid_i while ready_o = 0 is ignored; no state changes.
- A first beat carrying last_i produces a single-term result with cnt = 1.
- Reset asserted in any state returns every register to its reset value immediately. A partial accumulation or resolve is discarded.
- PS+PC per beat is assumed below 2^width (upstream guarantee). The accumulated sum wraps modulo 2^accWidth with no flag.

## Timing
- Throughput in ACC: 1 beat/cycle.
- Latency: the last beat is accepted at edge e0. RESOLVE occupies edges e1..eN. valid_o is high after edge eN, which is N cycles after e0 (3 at defaults).
- valid_o, sum_o and cnt_o are registered. ready_o is registered-state-derived and glitch-free.
- After the result handshake at edge eH, ready_o is high in the cycle after eH.
- Minimum period between the last beats of consecutive results: N+2 cycles (ACC accept, N resolve cycles, OUT with ready_i = 1).

## Test plan
- Reset: hold rst_ni = 0 with random inputs -> sum_o = 0, cnt_o = 0, valid_o = 0, ready_o = 1. Deassert rst_ni -> no output change.
- Single beat: ps = 0x1234, pc = 0x0F0F, last = 1 -> ready_o low for 4 cycles. valid_o rises exactly 3 cycles after acceptance with sum_o = 0x002143, cnt_o = 1.
- Cross-chunk carries: beats (0xFFFF, 0x0001), (0x8000, 0x8000), (0x00FF, 0xFF00 with last) -> sum_o = 0x02FFFF, cnt_o = 3.
- Wrap and saturation: 257 beats of (0xFFFF, 0x0000), the last with last = 1 -> sum_o = 0x00FEFF (257*0xFFFF mod 2^24), cnt_o = 255.
- Backpressure: complete a result and hold ready_i = 0 for 5 cycles while driving valid_i = 1 -> sum_o and valid_o stay stable, ready_o = 0, no beat consumed. Then ready_i = 1 -> the next result starts from 0.
- Reset mid-RESOLVE: drop rst_ni for 1 cycle at k = 1 -> outputs return to reset values. A following single beat (0x0010, 0x0001) yields sum_o = 0x000011, cnt_o = 1.
